// File: rtl/manchester_tx_serializer.sv
// Serial line driver for pre-encoded Manchester chip words: MSB chip first,
// HALF_PERIOD clocks per chip, one-word holding buffer for gapless back-to-back frames.
//
// state | meaning
// IDLE  | line at IDLE_LEVEL, shifter empty, waiting for a word
// SEND  | shifting chips out; hold register may carry the next word
module manchester_tx_serializer #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx_out,
    output logic        tx_active,
    output logic        frame_done,
    output logic        sym_err
);

    localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_n;
    logic [15:0]   shifter, shifter_n;
    logic [15:0]   hold, hold_n;
    logic          hold_full, hold_full_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    chip_idx, chip_idx_n;
    logic          tx_out_n, tx_active_n, frame_done_n, sym_err_n;
    logic          accept;
    logic [7:0]    pair_bad;

    assign word_ready = !hold_full;
    assign accept     = word_valid && !hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shifter    <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            cnt        <= '0;
            chip_idx   <= '0;
            tx_out     <= IDLE_LEVEL;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
            sym_err    <= 1'b0;
        end else begin
            state      <= state_n;
            shifter    <= shifter_n;
            hold       <= hold_n;
            hold_full  <= hold_full_n;
            cnt        <= cnt_n;
            chip_idx   <= chip_idx_n;
            tx_out     <= tx_out_n;
            tx_active  <= tx_active_n;
            frame_done <= frame_done_n;
            sym_err    <= sym_err_n;
        end
    end

    // A chip pair is legal only when its two chips differ.
    always_comb begin
        pair_bad = '0;
        for (int k = 0; k < 8; k++) begin
            pair_bad[k] = ~(word_in[2*k+1] ^ word_in[2*k]);
        end
    end

    always_comb begin
        state_n      = state;
        shifter_n    = shifter;
        hold_n       = hold;
        hold_full_n  = hold_full;
        cnt_n        = cnt;
        chip_idx_n   = chip_idx;
        tx_out_n     = tx_out;
        tx_active_n  = tx_active;
        frame_done_n = 1'b0;
        sym_err_n    = accept && (|pair_bad);

        case (state)
            IDLE: begin
                tx_out_n    = IDLE_LEVEL;
                tx_active_n = 1'b0;
                if (accept) begin
                    shifter_n   = word_in;
                    tx_out_n    = word_in[15];
                    tx_active_n = 1'b1;
                    cnt_n       = '0;
                    chip_idx_n  = '0;
                    state_n     = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    hold_n      = word_in;
                    hold_full_n = 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (chip_idx != 4'd15) begin
                        chip_idx_n = chip_idx + 4'd1;
                        shifter_n  = {shifter[14:0], 1'b0};
                        tx_out_n   = shifter[14];
                    end else begin
                        frame_done_n = 1'b1;
                        chip_idx_n   = '0;
                        // Accept and drain are mutually exclusive: accept needs hold empty.
                        if (hold_full) begin
                            shifter_n   = hold;
                            tx_out_n    = hold[15];
                            hold_full_n = 1'b0;
                        end else begin
                            tx_out_n    = IDLE_LEVEL;
                            tx_active_n = 1'b0;
                            state_n     = IDLE;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_manchester_tx_serializer.sv
// Directed bench for manchester_tx_serializer: HALF_PERIOD=4/IDLE=0 instance
// plus a HALF_PERIOD=1/IDLE=1 instance.
module tb_manchester_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready, tx_out, tx_active, frame_done, sym_err;
    logic [15:0] word_in1 = '0;
    logic        word_valid1 = 1'b0;
    logic        word_ready1, tx_out1, tx_active1, frame_done1, sym_err1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    manchester_tx_serializer #(.HALF_PERIOD(4), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .tx_out(tx_out), .tx_active(tx_active),
        .frame_done(frame_done), .sym_err(sym_err)
    );

    manchester_tx_serializer #(.HALF_PERIOD(1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in1), .word_valid(word_valid1),
        .word_ready(word_ready1), .tx_out(tx_out1), .tx_active(tx_active1),
        .frame_done(frame_done1), .sym_err(sym_err1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({tx_out, tx_active, word_ready, frame_done, sym_err} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00100",
                     {tx_out, tx_active, word_ready, frame_done, sym_err});
        end
        total++;
        if ({tx_out1, tx_active1, word_ready1} !== 3'b101) begin
            bad++;
            $display("FAIL reset_hp1 got=%b want=101", {tx_out1, tx_active1, word_ready1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [15:0] w, input logic exp_err);
        logic exp_bit;
        @(negedge clk);
        word_in = w;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        total++;
        if (sym_err !== exp_err) begin
            bad++;
            $display("FAIL single_sym_err w=%h got=%b want=%b", w, sym_err, exp_err);
        end
        for (int i = 0; i <= 64; i++) begin
            if (i > 0) @(negedge clk);
            exp_bit = (i < 64) ? w[15 - i/4] : 1'b0;
            total++;
            if (tx_out !== exp_bit || tx_active !== (i < 64) || frame_done !== (i == 64)
                || (i > 0 && sym_err !== 1'b0)) begin
                bad++;
                $display("FAIL single_line w=%h cyc=%0d got tx=%b act=%b fd=%b se=%b want tx=%b act=%b fd=%b se=0",
                         w, i, tx_out, tx_active, frame_done, sym_err,
                         exp_bit, (i < 64), (i == 64));
            end
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b0 || tx_out !== 1'b0) begin
            bad++;
            $display("FAIL single_after w=%h got fd=%b tx=%b want fd=0 tx=0", w, frame_done, tx_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        logic        exp_bit, exp_rdy;
        @(negedge clk);
        word_in = 16'h6666;
        word_valid = 1'b1;
        for (int i = 0; i <= 128; i++) begin
            @(negedge clk);
            w = (i < 64) ? 16'h6666 : 16'h9999;
            exp_bit = (i < 128) ? w[15 - (i % 64)/4] : 1'b0;
            exp_rdy = !(i >= 1 && i < 64);
            total++;
            if (tx_out !== exp_bit || tx_active !== (i < 128) || word_ready !== exp_rdy
                || frame_done !== (i == 64 || i == 128)) begin
                bad++;
                $display("FAIL b2b cyc=%0d got tx=%b act=%b rdy=%b fd=%b want tx=%b act=%b rdy=%b fd=%b",
                         i, tx_out, tx_active, word_ready, frame_done,
                         exp_bit, (i < 128), exp_rdy, (i == 64 || i == 128));
            end
            if (i == 0) word_in = 16'h9999;
            if (i == 1) word_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] words [3];
        logic [15:0] w;
        logic        exp_bit, rdy_prev;
        int          fd_count = 0;
        words[0] = 16'h6969;
        words[1] = 16'h9696;
        words[2] = 16'h5A5A;
        rdy_prev = 1'b0;
        @(negedge clk);
        word_in = words[0];
        word_valid = 1'b1;
        for (int i = 0; i <= 194; i++) begin
            @(negedge clk);
            if (i >= 2 && word_valid && rdy_prev) word_valid = 1'b0;
            w = words[(i < 192) ? i/64 : 2];
            exp_bit = (i < 192) ? w[15 - (i % 64)/4] : 1'b0;
            total++;
            if (tx_out !== exp_bit || tx_active !== (i < 192)) begin
                bad++;
                $display("FAIL bp_line cyc=%0d got tx=%b act=%b want tx=%b act=%b",
                         i, tx_out, tx_active, exp_bit, (i < 192));
            end
            if (i == 1 || i == 63 || i == 64 || i == 65) begin
                total++;
                if (word_ready !== (i == 64)) begin
                    bad++;
                    $display("FAIL bp_ready cyc=%0d got=%b want=%b", i, word_ready, (i == 64));
                end
            end
            if (frame_done) fd_count++;
            rdy_prev = word_ready;
            if (i == 0) word_in = words[1];
            if (i == 1) word_in = words[2];
        end
        total++;
        if (fd_count != 3) begin
            bad++;
            $display("FAIL bp_frames got=%0d want=3", fd_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        word_in = 16'h9999;
        word_valid = 1'b1;
        @(negedge clk);
        word_in = 16'h6666;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (27) @(negedge clk);
        total++;
        if (tx_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_reset got tx=%b want 1", tx_out);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (tx_out !== 1'b0 || tx_active !== 1'b0 || word_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_async got tx=%b act=%b rdy=%b want 0 0 1", tx_out, tx_active, word_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (tx_out !== 1'b0 || tx_active !== 1'b0) begin
                bad++;
                $display("FAIL mid_discard got tx=%b act=%b want 0 0", tx_out, tx_active);
            end
        end
    endtask

    task automatic test_hp1();
        logic [15:0] w;
        w = 16'h5555;
        @(negedge clk);
        word_in1 = w;
        word_valid1 = 1'b1;
        @(negedge clk);
        word_valid1 = 1'b0;
        for (int i = 0; i <= 17; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (tx_out1 !== ((i < 16) ? w[15 - i] : 1'b1) || tx_active1 !== (i < 16)
                || frame_done1 !== (i == 16)) begin
                bad++;
                $display("FAIL hp1 cyc=%0d got tx=%b act=%b fd=%b want tx=%b act=%b fd=%b",
                         i, tx_out1, tx_active1, frame_done1,
                         ((i < 16) ? w[15 - i] : 1'b1), (i < 16), (i == 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(16'hA55A, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_single(16'hA5A7, 1'b1);
        test_reset_mid();
        test_single(16'hA55A, 1'b0);
        test_hp1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
